// File: rtl/fifo_arb_pkg.sv
// Shared definitions for fifo_wr_arbiter: FSM state encoding and width helpers.
// Optional stall counter is enabled by defining FIFO_WR_ARB_STALL_CNT_EN.
package fifo_arb_pkg;

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] OWN  = 1'b1;

  localparam int unsigned N_DEF         = 4;
  localparam int unsigned MAX_BURST_DEF = 8;

  // Widths for the default configuration; parameterised instances use the helpers
  localparam int unsigned OW = $clog2(N_DEF);
  localparam int unsigned CW = $clog2(MAX_BURST_DEF + 1);

  function automatic int unsigned ow_of(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  function automatic int unsigned cw_of(input int unsigned max_burst);
    return $clog2(max_burst + 1);
  endfunction

endpackage

// File: rtl/fifo_wr_arbiter_if.sv
// Requester/FIFO write-port bundle shared by fifo_wr_arbiter and its neighbours.
interface fifo_wr_arbiter_if #(
  parameter int unsigned N = 4,
  parameter int unsigned B = 4
);
  logic [N-1:0]   req;
  logic [N*B-1:0] req_data;
  logic [N-1:0]   ack;
  logic           fifo_wr;
  logic [B-1:0]   fifo_w_data;
  logic           fifo_full;

  modport master (
    input  req, req_data, fifo_full,
    output ack, fifo_wr, fifo_w_data
  );

  modport slave (
    output req, req_data, fifo_full,
    input  ack, fifo_wr, fifo_w_data
  );
endinterface

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Combinational round-robin picker: first set bit of req searching upward from last+1 with wrap.
module rr_pick
  import fifo_arb_pkg::*;
#(
  parameter int unsigned N = 4
) (
  input  logic [N-1:0]          req,
  input  logic [ow_of(N)-1:0]   last,
  output logic [ow_of(N)-1:0]   idx,
  output logic                  any
);

  localparam int unsigned OWL = ow_of(N);

  // Distance k from last decides priority; indices >= N never match
  always_comb begin
    idx = '0;
    any = 1'b0;
    for (int k = 1; k <= int'(N); k++) begin
      for (int i = 0; i < int'(N); i++) begin
        if (!any && req[i] && (i == ((int'(last) + k) % int'(N)))) begin
          idx = OWL'(i);
          any = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among N producers, bursts of up to MAX_BURST.
// Define FIFO_WR_ARB_STALL_CNT_EN to enable the saturating 16-bit stall counter.
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int unsigned N         = N_DEF,
  parameter int unsigned B         = 4,
  parameter int unsigned MAX_BURST = MAX_BURST_DEF
) (
  input  logic                  clk,
  input  logic                  reset,
  fifo_wr_arbiter_if.master     bus,
  output logic [ow_of(N)-1:0]   owner,
  output logic                  busy,
  output logic [15:0]           stall_cnt
);

  localparam int unsigned OWL = ow_of(N);
  localparam int unsigned CWL = cw_of(MAX_BURST);

  logic [0:0]     r_state, w_state_nxt;
  logic [OWL-1:0] r_owner, w_owner_nxt;
  logic [OWL-1:0] r_last, w_last_nxt;
  logic [CWL-1:0] r_cnt, w_cnt_nxt, w_cnt_inc;
  logic           r_busy;
  logic [OWL-1:0] w_pick;
  logic           w_any;
  logic           w_req_own;
  logic [B-1:0]   w_own_data;
  logic           w_wr;

  rr_pick #(.N(N)) u_rr_pick (
    .req  (bus.req),
    .last (r_last),
    .idx  (w_pick),
    .any  (w_any)
  );

  // Request and data of the current owner
  always_comb begin
    w_req_own  = 1'b0;
    w_own_data = '0;
    for (int i = 0; i < int'(N); i++) begin
      if (r_owner == OWL'(i)) begin
        w_req_own  = bus.req[i];
        w_own_data = bus.req_data[i*int'(B) +: B];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_owner <= '0;
      r_last  <= OWL'(N - 1);
      r_cnt   <= '0;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_owner <= w_owner_nxt;
      r_last  <= w_last_nxt;
      r_cnt   <= w_cnt_nxt;
      r_busy  <= (w_state_nxt == OWN);
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_owner_nxt = r_owner;
    w_last_nxt  = r_last;
    w_cnt_nxt   = r_cnt;
    w_cnt_inc   = r_cnt + CWL'(1);
    w_wr        = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_any) begin
          w_owner_nxt = w_pick;
          w_cnt_nxt   = '0;
          w_state_nxt = OWN;
        end
      end
      OWN: begin
        if (!w_req_own) begin
          w_state_nxt = IDLE;
          w_last_nxt  = r_owner;
        end else if (!bus.fifo_full) begin
          w_wr      = 1'b1;
          w_cnt_nxt = w_cnt_inc;
          if (w_cnt_inc == CWL'(MAX_BURST)) begin
            w_state_nxt = IDLE;
            w_last_nxt  = r_owner;
          end
        end
      end
      default: w_state_nxt = IDLE;
    endcase
    // A burst interrupted by reset must not write in the reset cycle
    if (reset) w_wr = 1'b0;
  end

  always_comb begin
    bus.ack = '0;
    for (int i = 0; i < int'(N); i++) begin
      bus.ack[i] = w_wr && (r_owner == OWL'(i));
    end
  end

  assign bus.fifo_wr     = w_wr;
  assign bus.fifo_w_data = w_wr ? w_own_data : '0;
  assign owner           = r_owner;
  assign busy            = r_busy;

`ifdef FIFO_WR_ARB_STALL_CNT_EN
  logic [15:0] r_stall_cnt;
  logic        w_stall;

  assign w_stall = (r_state == OWN) && w_req_own && bus.fifo_full;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_stall_cnt <= '0;
    end else if (w_stall && (r_stall_cnt != 16'hFFFF)) begin
      r_stall_cnt <= r_stall_cnt + 16'd1;
    end
  end

  assign stall_cnt = r_stall_cnt;
`else
  assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed self-checking bench for fifo_wr_arbiter (MAX_BURST=8 and MAX_BURST=1 instances).
module tb_fifo_wr_arbiter;
  import fifo_arb_pkg::*;

  logic          clk = 1'b0;
  logic          reset;
  logic [OW-1:0] owner8, owner1;
  logic          busy8, busy1;
  logic [15:0]   stall8, stall1;
  int            n_checks = 0;
  int            n_fail   = 0;
  int            wc[4];

`ifdef FIFO_WR_ARB_STALL_CNT_EN
  localparam int STALL_EXP = 5;
`else
  localparam int STALL_EXP = 0;
`endif

  fifo_wr_arbiter_if #(.N(4), .B(4)) bus8 ();
  fifo_wr_arbiter_if #(.N(4), .B(4)) bus1 ();

  fifo_wr_arbiter #(.N(4), .B(4), .MAX_BURST(8)) u_dut8 (
    .clk(clk), .reset(reset), .bus(bus8.master),
    .owner(owner8), .busy(busy8), .stall_cnt(stall8)
  );

  fifo_wr_arbiter #(.N(4), .B(4), .MAX_BURST(1)) u_dut1 (
    .clk(clk), .reset(reset), .bus(bus1.master),
    .owner(owner1), .busy(busy1), .stall_cnt(stall1)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] dval(input int i, input int w);
    return 4'(i * 5 + w + 1);
  endfunction

  function automatic logic [15:0] pack_data();
    logic [15:0] d;
    for (int i = 0; i < 4; i++) d[i*4 +: 4] = dval(i, wc[i]);
    return d;
  endfunction

  // Drive one cycle on the MAX_BURST=8 instance and check the write port
  task automatic step8(input string t, input int c, input logic [3:0] rq, input logic full,
                       input bit exp_wr, input int exp_own);
    bus8.req       = rq;
    bus8.fifo_full = full;
    bus8.req_data  = pack_data();
    #1;
    chk($sformatf("%s.c%0d.wr", t, c), 32'(bus8.fifo_wr), 32'(exp_wr));
    chk($sformatf("%s.c%0d.ack", t, c), 32'(bus8.ack), exp_wr ? (32'd1 << exp_own) : 32'd0);
    if (exp_wr) begin
      chk($sformatf("%s.c%0d.data", t, c), 32'(bus8.fifo_w_data), 32'(dval(exp_own, wc[exp_own])));
      chk($sformatf("%s.c%0d.own", t, c), 32'(owner8), 32'(exp_own));
      wc[exp_own]++;
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    bus8.req = '0; bus8.req_data = '0; bus8.fifo_full = 1'b0;
    bus1.req = '0; bus1.req_data = '0; bus1.fifo_full = 1'b0;
    for (int i = 0; i < 4; i++) wc[i] = 0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("rst.busy", 32'(busy8), 32'd0);
    chk("rst.owner", 32'(owner8), 32'd0);
    chk("rst.wr", 32'(bus8.fifo_wr), 32'd0);
    chk("rst.ack", 32'(bus8.ack), 32'd0);
    chk("rst.data", 32'(bus8.fifo_w_data), 32'd0);
    chk("rst.stall", 32'(stall8), 32'd0);
    chk("rst.busy1", 32'(busy1), 32'd0);
    chk("rst.stall1", 32'(stall1), 32'd0);
  endtask

  initial begin
    reset = 1'b1;

    // Single requester 2: bursts of 8 separated by one idle cycle
    do_reset();
    for (int c = 0; c <= 22; c++) begin
      step8("single", c, 4'b0100, 1'b0, (c % 9) != 0, 2);
      @(negedge clk);
    end
    step8("single", 23, 4'b0000, 1'b0, 1'b0, 2);
    chk("single.cnt", 32'(wc[2]), 32'd20);
    @(negedge clk);

    // All requesting: owners rotate 0,1,2,3,0
    do_reset();
    for (int c = 0; c <= 44; c++) begin
      step8("all", c, 4'b1111, 1'b0, (c % 9) != 0, (c / 9) % 4);
      @(negedge clk);
    end

    // Owner 1 stalls 5 cycles on full, then completes the 8-word burst
    do_reset();
    for (int c = 0; c <= 14; c++) begin
      step8("stall", c, 4'b0010, (c >= 4 && c <= 8), (c >= 1 && c <= 3) || (c >= 9 && c <= 13), 1);
      if (c >= 4 && c <= 8) begin
        chk($sformatf("stall.c%0d.own", c), 32'(owner8), 32'd1);
        chk($sformatf("stall.c%0d.busy", c), 32'(busy8), 32'd1);
      end
      if (c == 14) begin
        chk("stall.release", 32'(busy8), 32'd0);
        chk("stall.cnt", 32'(stall8), 32'(STALL_EXP));
      end
      @(negedge clk);
    end
    chk("stall.words", 32'(wc[1]), 32'd8);

    // Owner 0 drops after 3 words; requester 3 follows after one idle cycle
    do_reset();
    for (int c = 0; c <= 3; c++) begin
      step8("drop", c, 4'b1001, 1'b0, c >= 1, 0);
      @(negedge clk);
    end
    step8("drop", 4, 4'b1000, 1'b0, 1'b0, 0);
    chk("drop.c4.busy", 32'(busy8), 32'd1);
    @(negedge clk);
    step8("drop", 5, 4'b1000, 1'b0, 1'b0, 3);
    chk("drop.c5.busy", 32'(busy8), 32'd0);
    @(negedge clk);
    step8("drop", 6, 4'b1000, 1'b0, 1'b1, 3);
    @(negedge clk);

    // Reset while owner 2 is at burst_cnt=4
    do_reset();
    for (int c = 0; c <= 4; c++) begin
      step8("mrst", c, 4'b0100, 1'b0, c >= 1, 2);
      @(negedge clk);
    end
    reset = 1'b1;
    bus8.req = 4'b0101;
    #1;
    chk("mrst.c5.wr", 32'(bus8.fifo_wr), 32'd0);
    chk("mrst.c5.ack", 32'(bus8.ack), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    step8("mrst", 6, 4'b0101, 1'b0, 1'b0, 0);
    chk("mrst.c6.busy", 32'(busy8), 32'd0);
    chk("mrst.c6.stall", 32'(stall8), 32'd0);
    chk("mrst.c6.own", 32'(owner8), 32'd0);
    @(negedge clk);
    step8("mrst", 7, 4'b0101, 1'b0, 1'b1, 0);
    @(negedge clk);

    // MAX_BURST=1: alternating single writes 0,1,0,1 with idle cycles between
    do_reset();
    for (int c = 0; c <= 8; c++) begin
      bus1.req      = 4'b0011;
      bus1.req_data = {dval(3, 0), dval(2, 0), dval(1, 0), dval(0, 0)};
      #1;
      chk($sformatf("mb1.c%0d.wr", c), 32'(bus1.fifo_wr), 32'(c % 2));
      if (c % 2 == 1) begin
        chk($sformatf("mb1.c%0d.own", c), 32'(owner1), 32'(((c - 1) / 2) % 2));
        chk($sformatf("mb1.c%0d.ack", c), 32'(bus1.ack), 32'd1 << (((c - 1) / 2) % 2));
        chk($sformatf("mb1.c%0d.data", c), 32'(bus1.fifo_w_data), 32'(dval(((c - 1) / 2) % 2, 0)));
      end else begin
        chk($sformatf("mb1.c%0d.ack", c), 32'(bus1.ack), 32'd0);
      end
      @(negedge clk);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
